avr_pp_target: RTL

//  DUT-side responder for the AVR high-voltage parallel programming interface driven by the ZIF bottomhalf.

---
 rtl/avr_pp_target.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/avr_pp_target.sv
`default_nettype none
// ============================================================================
// Module   : avr_pp_target
// Purpose  : AVR high-voltage parallel-programming target model. It decodes
//            XTAL1/PAGEL//WR//OE strobes, fills a page buffer, programs or
//            erases a flash array and drives read-back data. Defining
//            AVR_PP_SIG_EN enables signature-byte reads (cmd 8'h08).
// Revision : 1.0  initial release
// ============================================================================
module avr_pp_target #(
    parameter int          FLASH_AW    = 8,
    parameter int          PAGE_AW     = 4,
    parameter int          BUSY_CYCLES = 64,
    parameter logic [23:0] SIG         = 24'h1E9502
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pp_en,
    input  logic       xtal1,
    input  logic       wr_n,
    input  logic       oe_n,
    input  logic       pagel,
    input  logic       xa1,
    input  logic       xa0,
    input  logic       bs1,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       rdy
);

    localparam int FLASH_WORDS = 2 ** FLASH_AW;
    localparam int PAGE_WORDS  = 2 ** PAGE_AW;
    localparam int BUSY_TOTAL  = (BUSY_CYCLES > PAGE_WORDS) ? BUSY_CYCLES : PAGE_WORDS;
    localparam int CNT_MAX     = (BUSY_TOTAL > FLASH_WORDS) ? BUSY_TOTAL : FLASH_WORDS;
    localparam int CNT_W       = $clog2(CNT_MAX) + 1;
    localparam logic [15:0] SYNC_RST = 16'h3000;

`ifdef AVR_PP_SIG_EN
    localparam logic SIG_EN = 1'b1;
`else
    localparam logic SIG_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROG  = 2'd1,
        ST_ERASE = 2'd2
    } state_t;

    logic [15:0]      sync1_q, sync2_q, sync1_d, sync2_d;
    logic [2:0]       prev_q, prev_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       cmd_q, cmd_d, data_lo_q, data_lo_d, data_hi_q, data_hi_d;
    logic [15:0]      addr_q, addr_d;
    logic [7:0]       data_out_q, data_out_d;
    logic             data_oe_q, data_oe_d;

    logic [15:0] flash_mem [FLASH_WORDS];
    logic [15:0] page_mem  [PAGE_WORDS];

    logic                flash_we, page_we;
    logic [FLASH_AW-1:0] flash_wa;
    logic [PAGE_AW-1:0]  page_wa;
    logic [15:0]         flash_wd, page_wd, rd_word;
    logic [7:0]          sig_byte;

    // Synchronized copies: {pp_en, xtal1, wr_n, oe_n, pagel, xa1, xa0, bs1, data_in}
    logic       pp_en_s, xtal1_s, wr_n_s, oe_n_s, pagel_s, xa1_s, xa0_s, bs1_s;
    logic [7:0] din_s;
    logic       xtal1_rise, wr_fall, pagel_rise;

    assign {pp_en_s, xtal1_s, wr_n_s, oe_n_s, pagel_s, xa1_s, xa0_s, bs1_s, din_s} = sync2_q;
    assign xtal1_rise = xtal1_s & ~prev_q[2];
    assign wr_fall    = ~wr_n_s & prev_q[1];
    assign pagel_rise = pagel_s & ~prev_q[0];

    assign rd_word = flash_mem[addr_q[FLASH_AW-1:0]];

    always_comb begin
        sig_byte = 8'h00;
        case (addr_q[1:0])
            2'd0:    sig_byte = SIG[23:16];
            2'd1:    sig_byte = SIG[15:8];
            2'd2:    sig_byte = SIG[7:0];
            default: sig_byte = 8'h00;
        endcase
    end

    always_comb begin
        sync1_d    = {pp_en, xtal1, wr_n, oe_n, pagel, xa1, xa0, bs1, data_in};
        sync2_d    = sync1_q;
        prev_d     = {xtal1_s, wr_n_s, pagel_s};
        state_d    = state_q;
        cnt_d      = cnt_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        data_lo_d  = data_lo_q;
        data_hi_d  = data_hi_q;
        data_out_d = data_out_q;
        data_oe_d  = 1'b0;
        flash_we   = 1'b0;
        flash_wa   = '0;
        flash_wd   = '0;
        page_we    = 1'b0;
        page_wa    = '0;
        page_wd    = '0;

        case (state_q)
            ST_IDLE: begin
                if (pp_en_s) begin
                    if (xtal1_rise) begin
                        case ({xa1_s, xa0_s})
                            2'b00: if (bs1_s) addr_d[15:8] = din_s; else addr_d[7:0] = din_s;
                            2'b01: if (bs1_s) data_hi_d = din_s;    else data_lo_d = din_s;
                            2'b10: cmd_d = din_s;
                            default: ;
                        endcase
                    end
                    // PAGEL sees any XTAL1 load from the same cycle
                    if (pagel_rise) begin
                        page_we = 1'b1;
                        page_wa = addr_d[PAGE_AW-1:0];
                        page_wd = {data_hi_d, data_lo_d};
                    end
                    if (wr_fall && cmd_q == 8'h10) begin
                        state_d = ST_PROG;
                        cnt_d   = '0;
                    end else if (wr_fall && cmd_q == 8'h80) begin
                        state_d = ST_ERASE;
                        cnt_d   = '0;
                    end
                    if (!oe_n_s && cmd_q == 8'h02) begin
                        data_oe_d  = 1'b1;
                        data_out_d = bs1_s ? rd_word[15:8] : rd_word[7:0];
                    end else if (!oe_n_s && SIG_EN && cmd_q == 8'h08) begin
                        data_oe_d  = 1'b1;
                        data_out_d = sig_byte;
                    end
                end
            end
            ST_PROG: begin
                if (cnt_q < CNT_W'(PAGE_WORDS)) begin
                    flash_we = 1'b1;
                    flash_wa = {addr_q[FLASH_AW-1:PAGE_AW], cnt_q[PAGE_AW-1:0]};
                    flash_wd = page_mem[cnt_q[PAGE_AW-1:0]];
                end
                if (cnt_q == CNT_W'(BUSY_TOTAL - 1)) state_d = ST_IDLE;
                else                                 cnt_d   = cnt_q + 1'b1;
            end
            ST_ERASE: begin
                flash_we = 1'b1;
                flash_wa = cnt_q[FLASH_AW-1:0];
                flash_wd = 16'hFFFF;
                if (cnt_q == CNT_W'(FLASH_WORDS - 1)) state_d = ST_IDLE;
                else                                  cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= SYNC_RST;
            sync2_q    <= SYNC_RST;
            prev_q     <= 3'b010;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cmd_q      <= '0;
            addr_q     <= '0;
            data_lo_q  <= '0;
            data_hi_q  <= '0;
            data_out_q <= '0;
            data_oe_q  <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            data_lo_q  <= data_lo_d;
            data_hi_q  <= data_hi_d;
            data_out_q <= data_out_d;
            data_oe_q  <= data_oe_d;
        end
    end

    // Storage arrays are deliberately not reset; an aborted erase leaves partial contents
    always_ff @(posedge clk) begin
        if (flash_we) flash_mem[flash_wa] <= flash_wd;
        if (page_we)  page_mem[page_wa]   <= page_wd;
    end

    generate
        if (FLASH_AW < 16) begin : g_addr_hi_unused
            logic unused_addr_hi;
            assign unused_addr_hi = ^addr_q[15:FLASH_AW];
        end
    endgenerate

    assign data_out = data_out_q;
    assign data_oe  = data_oe_q;
    assign rdy      = (state_q == ST_IDLE);

endmodule
`default_nettype wire
